maq_regressivo: RTL and testbench

Countdown timer for the digital clock: counts a loaded MM:SS value down to 00:00, one step per seconds-enable pulse, using a BCD borrow chain. It is the decrementing counterpart of the clock's minute/second up-counters. It shares their seconds-enable pulse and digit format, so its digits feed the same display path. On reaching zero it raises a one-cycle `fim` pulse and holds an alarm level for a programmable number of seconds.

---
 rtl/maq_pkg.sv | 29 ++
 rtl/maq_dec_digito.sv | 26 ++
 rtl/maq_regressivo.sv | 151 +++++++++++++++
 tb/tb_maq_regressivo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/maq_pkg.sv
// Shared types and constants for the countdown timer.
package maq_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        ALARME   = 2'd3
    } maqr_estado_t;

    localparam int unsigned MAQ_MAX_LSD = 9;
    localparam int unsigned MAQ_MAX_MSD = 5;
    localparam int unsigned MAQ_LSD_W   = 4;
    localparam int unsigned MAQ_MSD_W   = 3;

    // MM:SS value in the display digit format
    typedef struct packed {
        logic [MAQ_MSD_W-1:0] msd_m;
        logic [MAQ_LSD_W-1:0] lsd_m;
        logic [MAQ_MSD_W-1:0] msd_s;
        logic [MAQ_LSD_W-1:0] lsd_s;
    } maqr_digitos_t;

    // Width of the alarm counter able to hold the given number of seconds
    function automatic int unsigned alarm_cnt_w(input int unsigned segundos);
        return $clog2(segundos + 1);
    endfunction

endpackage

// File: rtl/maq_dec_digito.sv
// One BCD digit decrementer: wraps 0 -> MAX and raises borrow_out.
module maq_dec_digito #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic [W-1:0] digito,
    input  logic         borrow_in,
    output logic [W-1:0] proximo,
    output logic         borrow_out
);

    // Decrement only when a borrow arrives from the lower digit
    always_comb begin
        proximo    = digito;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digito == W'(0)) begin
                proximo    = W'(MAX);
                borrow_out = 1'b1;
            end else begin
                proximo = digito - W'(1);
            end
        end
    end

endmodule

// File: rtl/maq_regressivo.sv
// MM:SS countdown timer with BCD borrow chain, end pulse and timed alarm.
module maq_regressivo
    import maq_pkg::*;
#(
    parameter int unsigned ALARM_SECONDS = 5
) (
    input  logic                 maqr_clock,
    input  logic                 maqr_reset_n,
    input  logic                 maqr_enable,
    input  logic                 maqr_load,
    input  logic [MAQ_MSD_W-1:0] maqr_load_msd_m,
    input  logic [MAQ_LSD_W-1:0] maqr_load_lsd_m,
    input  logic [MAQ_MSD_W-1:0] maqr_load_msd_s,
    input  logic [MAQ_LSD_W-1:0] maqr_load_lsd_s,
    input  logic                 maqr_start,
    input  logic                 maqr_stop,
    output logic [MAQ_MSD_W-1:0] maqr_msd_m,
    output logic [MAQ_LSD_W-1:0] maqr_lsd_m,
    output logic [MAQ_MSD_W-1:0] maqr_msd_s,
    output logic [MAQ_LSD_W-1:0] maqr_lsd_s,
    output logic                 maqr_running,
    output logic                 maqr_fim,
    output logic                 maqr_alarme,
    output logic                 maqr_load_err
);

    localparam int unsigned CNT_W = alarm_cnt_w(ALARM_SECONDS);

    maqr_estado_t  estado;
    maqr_digitos_t digitos;
    maqr_digitos_t digitos_dec;
    maqr_digitos_t digitos_load;
    logic [CNT_W-1:0] cnt_alarme;

    logic borrow_ss;
    logic borrow_sm;
    logic borrow_ms;
    logic borrow_mm;
    logic load_ok;
    logic zero;
    logic um;
    logic aceita_start;

    // Borrow chain: seconds units always receive the borrow
    maq_dec_digito #(.W(MAQ_LSD_W), .MAX(MAQ_MAX_LSD)) u_lsd_s (
        .digito(digitos.lsd_s), .borrow_in(1'b1),
        .proximo(digitos_dec.lsd_s), .borrow_out(borrow_ss)
    );
    maq_dec_digito #(.W(MAQ_MSD_W), .MAX(MAQ_MAX_MSD)) u_msd_s (
        .digito(digitos.msd_s), .borrow_in(borrow_ss),
        .proximo(digitos_dec.msd_s), .borrow_out(borrow_sm)
    );
    maq_dec_digito #(.W(MAQ_LSD_W), .MAX(MAQ_MAX_LSD)) u_lsd_m (
        .digito(digitos.lsd_m), .borrow_in(borrow_sm),
        .proximo(digitos_dec.lsd_m), .borrow_out(borrow_ms)
    );
    maq_dec_digito #(.W(MAQ_MSD_W), .MAX(MAQ_MAX_MSD)) u_msd_m (
        .digito(digitos.msd_m), .borrow_in(borrow_ms),
        .proximo(digitos_dec.msd_m), .borrow_out(borrow_mm)
    );

    // Load payload, validation and value decode
    always_comb begin
        digitos_load.msd_m = maqr_load_msd_m;
        digitos_load.lsd_m = maqr_load_lsd_m;
        digitos_load.msd_s = maqr_load_msd_s;
        digitos_load.lsd_s = maqr_load_lsd_s;
        load_ok = (maqr_load_msd_m <= MAQ_MSD_W'(MAQ_MAX_MSD)) &&
                  (maqr_load_lsd_m <= MAQ_LSD_W'(MAQ_MAX_LSD)) &&
                  (maqr_load_msd_s <= MAQ_MSD_W'(MAQ_MAX_MSD)) &&
                  (maqr_load_lsd_s <= MAQ_LSD_W'(MAQ_MAX_LSD));
        zero = (digitos == '0);
        um   = (digitos == maqr_digitos_t'(14'd1));
        aceita_start = maqr_start && !maqr_stop && !zero;
    end

    // FSM, digit registers and alarm counter
    always_ff @(posedge maqr_clock or negedge maqr_reset_n) begin
        if (!maqr_reset_n) begin
            estado        <= OCIOSO;
            digitos       <= '0;
            cnt_alarme    <= '0;
            maqr_running  <= 1'b0;
            maqr_fim      <= 1'b0;
            maqr_alarme   <= 1'b0;
            maqr_load_err <= 1'b0;
        end else begin
            maqr_fim      <= 1'b0;
            maqr_load_err <= 1'b0;
            case (estado)
                OCIOSO, PAUSADO: begin
                    if (maqr_load) begin
                        if (load_ok) begin
                            digitos <= digitos_load;
                            estado  <= OCIOSO;
                        end else begin
                            maqr_load_err <= 1'b1;
                        end
                    end else if (aceita_start) begin
                        estado       <= CONTANDO;
                        maqr_running <= 1'b1;
                    end
                end
                CONTANDO: begin
                    if (maqr_stop) begin
                        estado       <= PAUSADO;
                        maqr_running <= 1'b0;
                    end else if (maqr_enable && !borrow_mm) begin
                        digitos <= digitos_dec;
                        if (um) begin
                            estado       <= ALARME;
                            maqr_running <= 1'b0;
                            maqr_fim     <= 1'b1;
                            maqr_alarme  <= 1'b1;
                            cnt_alarme   <= CNT_W'(ALARM_SECONDS);
                        end
                    end
                end
                ALARME: begin
                    if (maqr_load) begin
                        if (load_ok) begin
                            digitos     <= digitos_load;
                            estado      <= OCIOSO;
                            maqr_alarme <= 1'b0;
                            cnt_alarme  <= '0;
                        end else begin
                            maqr_load_err <= 1'b1;
                        end
                    end else if (maqr_stop) begin
                        estado      <= OCIOSO;
                        maqr_alarme <= 1'b0;
                        cnt_alarme  <= '0;
                    end else if (maqr_enable) begin
                        cnt_alarme <= cnt_alarme - CNT_W'(1);
                        if (cnt_alarme == CNT_W'(1)) begin
                            estado      <= OCIOSO;
                            maqr_alarme <= 1'b0;
                        end
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign maqr_msd_m = digitos.msd_m;
    assign maqr_lsd_m = digitos.lsd_m;
    assign maqr_msd_s = digitos.msd_s;
    assign maqr_lsd_s = digitos.lsd_s;

endmodule

// File: tb/tb_maq_regressivo.sv
// Directed bench for the countdown timer.
module tb_maq_regressivo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [2:0] l_msd_m = '0;
    logic [3:0] l_lsd_m = '0;
    logic [2:0] l_msd_s = '0;
    logic [3:0] l_lsd_s = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] msd_m;
    logic [3:0] lsd_m;
    logic [2:0] msd_s;
    logic [3:0] lsd_s;
    logic       running;
    logic       fim;
    logic       alarme;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    maq_regressivo #(.ALARM_SECONDS(5)) dut (
        .maqr_clock(clk),
        .maqr_reset_n(rst_n),
        .maqr_enable(enable),
        .maqr_load(load),
        .maqr_load_msd_m(l_msd_m),
        .maqr_load_lsd_m(l_lsd_m),
        .maqr_load_msd_s(l_msd_s),
        .maqr_load_lsd_s(l_lsd_s),
        .maqr_start(start),
        .maqr_stop(stop),
        .maqr_msd_m(msd_m),
        .maqr_lsd_m(lsd_m),
        .maqr_msd_s(msd_s),
        .maqr_lsd_s(lsd_s),
        .maqr_running(running),
        .maqr_fim(fim),
        .maqr_alarme(alarme),
        .maqr_load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Digits packed as m1,m0,s1,s0 one hex nibble each
    function automatic logic [31:0] dig_obs();
        return {16'h0, 1'b0, msd_m, lsd_m, 1'b0, msd_s, lsd_s};
    endfunction

    function automatic logic [31:0] dig_exp(input int unsigned r);
        int unsigned m = r / 60;
        int unsigned s = r % 60;
        return {16'h0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic do_load(input int m1, input int m0, input int s1, input int s0,
                           input logic with_start);
        load = 1'b1; start = with_start;
        l_msd_m = 3'(m1); l_lsd_m = 4'(m0); l_msd_s = 3'(s1); l_lsd_s = 4'(s0);
        tick();
        load = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop(input logic with_enable);
        stop = 1'b1; enable = with_enable; tick(); stop = 1'b0; enable = 1'b0;
    endtask

    task automatic pulse_enable();
        enable = 1'b1; tick(); enable = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_digits", dig_obs(), 32'h0000);
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_fim", {31'h0, fim}, 32'h0);
        chk("rst_alarme", {31'h0, alarme}, 32'h0);
        chk("rst_load_err", {31'h0, load_err}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 01:05 countdown, 65 enables
        do_load(0, 1, 0, 5, 1'b0);
        chk("load105_digits", dig_obs(), 32'h0105);
        chk("load105_running", {31'h0, running}, 32'h0);
        chk("load105_err", {31'h0, load_err}, 32'h0);
        pulse_start();
        chk("start105_running", {31'h0, running}, 32'h1);
        chk("start105_digits", dig_obs(), 32'h0105);
        for (int i = 1; i <= 65; i++) begin
            pulse_enable();
            chk("cnt_digits", dig_obs(), dig_exp(65 - i));
            chk("cnt_fim", {31'h0, fim}, (i == 65) ? 32'h1 : 32'h0);
        end
        chk("zero_alarme", {31'h0, alarme}, 32'h1);
        chk("zero_running", {31'h0, running}, 32'h0);
        tick();
        chk("fim_one_cycle", {31'h0, fim}, 32'h0);
        chk("alarme_hold", {31'h0, alarme}, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            pulse_enable();
            chk("alarme_cnt", {31'h0, alarme}, (i < 5) ? 32'h1 : 32'h0);
        end
        chk("post_alarme_digits", dig_obs(), 32'h0000);
        pulse_start();
        chk("start_zero_ignored", {31'h0, running}, 32'h0);

        // Full borrow chain, stop beats enable, resume
        do_load(1, 0, 0, 0, 1'b0);
        pulse_start();
        pulse_enable();
        chk("borrow_chain", dig_obs(), 32'h0959);
        pulse_stop(1'b1);
        chk("stop_enable_digits", dig_obs(), 32'h0959);
        chk("stop_enable_running", {31'h0, running}, 32'h0);
        pulse_start();
        chk("resume_running", {31'h0, running}, 32'h1);
        chk("resume_no_dec", dig_obs(), 32'h0959);
        pulse_enable();
        chk("resume_dec", dig_obs(), 32'h0958);

        // Load ignored while counting
        do_load(0, 3, 3, 3, 1'b0);
        chk("load_cnt_digits", dig_obs(), 32'h0958);
        chk("load_cnt_running", {31'h0, running}, 32'h1);
        chk("load_cnt_err", {31'h0, load_err}, 32'h0);
        pulse_stop(1'b0);
        chk("pause_running", {31'h0, running}, 32'h0);
        // Load beats start in PAUSADO
        do_load(0, 2, 2, 2, 1'b1);
        chk("load_start_digits", dig_obs(), 32'h0222);
        chk("load_start_running", {31'h0, running}, 32'h0);
        pulse_start();
        chk("idle_start", {31'h0, running}, 32'h1);
        pulse_stop(1'b0);

        // Invalid loads in PAUSADO
        do_load(0, 2, 2, 10, 1'b0);
        chk("bad_lsd_err", {31'h0, load_err}, 32'h1);
        chk("bad_lsd_digits", dig_obs(), 32'h0222);
        tick();
        chk("bad_err_pulse", {31'h0, load_err}, 32'h0);
        do_load(6, 0, 0, 0, 1'b0);
        chk("bad_msd_err", {31'h0, load_err}, 32'h1);
        chk("bad_msd_digits", dig_obs(), 32'h0222);
        pulse_start();
        chk("bad_state_paused", {31'h0, running}, 32'h1);
        pulse_enable();
        chk("bad_resume_dec", dig_obs(), 32'h0221);
        pulse_stop(1'b0);

        // Stop silences the alarm
        do_load(0, 0, 0, 2, 1'b0);
        pulse_start();
        pulse_enable();
        chk("two_first", dig_obs(), 32'h0001);
        chk("two_first_fim", {31'h0, fim}, 32'h0);
        pulse_enable();
        chk("two_fim", {31'h0, fim}, 32'h1);
        chk("two_alarme", {31'h0, alarme}, 32'h1);
        pulse_stop(1'b0);
        chk("stop_alarme", {31'h0, alarme}, 32'h0);
        chk("stop_alarme_digits", dig_obs(), 32'h0000);
        pulse_start();
        chk("stop_alarme_idle", {31'h0, running}, 32'h0);

        // Asynchronous reset mid-count at 00:30
        do_load(0, 0, 4, 5, 1'b0);
        pulse_start();
        for (int i = 0; i < 15; i++) pulse_enable();
        chk("mid_digits", dig_obs(), 32'h0030);
        rst_n = 1'b0;
        #2;
        chk("async_digits", dig_obs(), 32'h0000);
        chk("async_running", {31'h0, running}, 32'h0);
        chk("async_fim", {31'h0, fim}, 32'h0);
        chk("async_alarme", {31'h0, alarme}, 32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("post_rst_fim", {31'h0, fim}, 32'h0);
        chk("post_rst_digits", dig_obs(), 32'h0000);
        pulse_start();
        chk("post_rst_start", {31'h0, running}, 32'h0);
        do_load(0, 0, 0, 10, 1'b0);
        chk("idle_bad_err", {31'h0, load_err}, 32'h1);
        chk("idle_bad_digits", dig_obs(), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
